logdrop_window_stream: RTL and testbench

- Streaming, clocked successor to the combinational logdrop window function.
- Applies a power-of-two ("logdrop") approximation of a tapered window to a continuous sample stream.
- Generalised to N_CH parallel channels, selectable window mode and an internal window-position counter.
- Sits between a sample source and any downstream correlator/accumulator, using valid/ready handshakes on both sides.

---
 rtl/logdrop_window_stream.sv | 146 ++++++++++++++
 tb/tb_logdrop_window_stream.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/logdrop_window_stream.sv
// Streaming power-of-two taper window over N_CH parallel channels sharing one window position.
// Latency: 2 cycles from accept to o_valid when not stalled; 1 sample/cycle throughput.
// Backpressure: skid-free two-stage pipeline; o_ready falls combinationally when both stages hold data and i_ready is low.
module logdrop_window_stream #(
  parameter int DATA_W = 8,
  parameter int WINLEN = 256,
  parameter int N_CH   = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [N_CH*DATA_W-1:0]     i_x,
  input  logic                       i_mode,
  input  logic                       i_restart,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [N_CH*DATA_W-1:0]     o_y,
  output logic [$clog2(WINLEN)-1:0]  o_t,
  output logic                       o_last
);

  localparam int L    = $clog2(WINLEN);
  localparam int SH_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [SH_W-1:0] LM1 = SH_W'(L - 1);

  // window position and the mode that governs the current window
  logic [L-1:0] t_cnt;
  logic         mode_q;

  // stage A
  logic                   a_valid;
  logic [N_CH*DATA_W-1:0] a_x;
  logic [L-1:0]           a_t;
  logic                   a_mode;
  logic                   a_last;

  // handshake and tagging
  logic         accept;
  logic         b_adv;
  logic         a_adv;
  logic [L-1:0] tag;
  logic         tag_is_t0;
  logic         eff_mode;

  // window shift for the sample sitting in stage A
  logic [L-2:0]           t_fold;
  logic [L-1:0]           u_plus1;
  logic [SH_W-1:0]        msb_pos;
  logic [SH_W-1:0]        shamt;
  logic [N_CH*DATA_W-1:0] y_nxt;

  // pipeline advance conditions; stage A may refill in the same cycle stage B drains
  always_comb begin
    b_adv   = !o_valid || i_ready;
    a_adv   = !a_valid || b_adv;
    o_ready = a_adv;
    accept  = i_valid && a_adv;
  end

  // tag the incoming sample; a t=0 sample uses the live i_mode since it opens a new window
  always_comb begin
    tag       = i_restart ? '0 : t_cnt;
    tag_is_t0 = (tag == '0);
    eff_mode  = tag_is_t0 ? i_mode : mode_q;
  end

  // window counter and window-mode register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      t_cnt  <= '0;
      mode_q <= 1'b1;
    end else begin
      if (accept) begin
        t_cnt <= tag + L'(1);
        if (tag_is_t0) begin
          mode_q <= i_mode;
        end
      end else if (i_restart) begin
        t_cnt <= '0;
      end
    end
  end

  // stage A register: sample, position, mode and end-of-window flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_valid <= 1'b0;
      a_x     <= '0;
      a_t     <= '0;
      a_mode  <= 1'b1;
      a_last  <= 1'b0;
    end else if (a_adv) begin
      a_valid <= accept;
      if (accept) begin
        a_x    <= i_x;
        a_t    <= tag;
        a_mode <= eff_mode;
        a_last <= (tag == '1);
      end
    end
  end

  // fold position about the window centre: WINLEN-1-t is the bitwise inverse of t
  always_comb begin
    t_fold  = a_t[L-1] ? ~a_t[L-2:0] : a_t[L-2:0];
    u_plus1 = {1'b0, t_fold} + L'(1);
  end

  // floor(log2(u+1)) via highest set bit; u+1 is never zero
  always_comb begin
    msb_pos = '0;
    for (int i = 0; i < L; i++) begin
      if (u_plus1[i]) begin
        msb_pos = SH_W'(i);
      end
    end
  end

  // attenuation shift per channel; rectangular mode passes samples through
  always_comb begin
    shamt = a_mode ? (LM1 - msb_pos) : '0;
    y_nxt = '0;
    for (int c = 0; c < N_CH; c++) begin
      y_nxt[c*DATA_W +: DATA_W] = a_x[c*DATA_W +: DATA_W] >> shamt;
    end
  end

  // stage B register: outputs hold their last values while empty or stalled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_y     <= '0;
      o_t     <= '0;
      o_last  <= 1'b0;
    end else if (b_adv) begin
      o_valid <= a_valid;
      if (a_valid) begin
        o_y    <= y_nxt;
        o_t    <= a_t;
        o_last <= a_last;
      end
    end
  end

endmodule

// File: tb/tb_logdrop_window_stream.sv
// Directed bench for logdrop_window_stream with DATA_W=8, WINLEN=256, N_CH=2.
// Checks window values, latency, backpressure, wrap/restart and async reset.
// Outputs are logged on the falling edge when a transfer is taking place.
module tb_logdrop_window_stream;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_x;
  logic        i_mode;
  logic        i_restart;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_y;
  logic [7:0]  o_t;
  logic        o_last;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [15:0] oy_q[$];
  logic [7:0]  ot_q[$];
  logic        ol_q[$];
  int          ocyc_q[$];
  int          acyc_q[$];

  logdrop_window_stream #(.DATA_W(8), .WINLEN(256), .N_CH(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_x(i_x), .i_mode(i_mode), .i_restart(i_restart), .o_valid(o_valid),
    .i_ready(i_ready), .o_y(o_y), .o_t(o_t), .o_last(o_last)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // transfer logger
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (i_valid && o_ready) acyc_q.push_back(cyc);
      if (o_valid && i_ready) begin
        oy_q.push_back(o_y);
        ot_q.push_back(o_t);
        ol_q.push_back(o_last);
        ocyc_q.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    oy_q.delete(); ot_q.delete(); ol_q.delete(); ocyc_q.delete(); acyc_q.delete();
  endtask

  // present one sample and hold it until it is taken (bounded)
  task automatic push(input logic [15:0] x, input logic m, input logic r);
    int guard;
    guard = 0;
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_x = x; i_mode = m; i_restart = r;
    @(negedge i_clk);
    while (!o_ready && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 100) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_drain();
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_restart = 1'b0; i_ready = 1'b1;
    repeat (6) @(posedge i_clk);
    #1;
  endtask

  // restart with no accept: counter returns to 0
  task automatic restart_idle();
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_restart = 1'b1;
    @(posedge i_clk); #1;
    i_restart = 1'b0;
  endtask

  initial begin
    int errs;
    int lows;
    int unstable;
    int g;
    logic [15:0] hold_y;
    logic [7:0]  hold_t;

    i_rst = 1'b1; i_valid = 1'b0; i_x = '0; i_mode = 1'b1;
    i_restart = 1'b0; i_ready = 1'b1;

    // reset state
    #2;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_y", o_y, 0);
    check("rst_o_t", o_t, 0);
    check("rst_o_last", o_last, 0);
    #21 i_rst = 1'b0;
    #1 check("rst_o_ready", o_ready, 1);
    clear_logs();

    // logdrop values over a full window
    for (int n = 0; n < 256; n++) push(16'h80FF, 1'b1, 1'b0);
    idle_drain();
    check("ld_count", oy_q.size(), 256);
    check("ld_y_t0", oy_q[0], 16'h0101);
    check("ld_t_t0", ot_q[0], 0);
    check("ld_y_t1", oy_q[1], 16'h0203);
    check("ld_y_t3", oy_q[3], 16'h0407);
    check("ld_y_t64", oy_q[64], 16'h407F);
    check("ld_y_t127", oy_q[127], 16'h80FF);
    check("ld_y_t128", oy_q[128], 16'h80FF);
    check("ld_y_t255", oy_q[255], 16'h0101);
    check("ld_t_t255", ot_q[255], 255);
    check("ld_last_t255", ol_q[255], 1);
    errs = 0;
    for (int i = 0; i < 255; i++) if (ol_q[i]) errs++;
    check("ld_last_only_end", errs, 0);
    errs = 0;
    for (int i = 0; i < 256; i++) if (ocyc_q[i] - acyc_q[i] != 2) errs++;
    check("ld_latency2", errs, 0);
    clear_logs();

    // rectangular window; mid-window i_mode change must not take effect
    for (int n = 0; n < 256; n++) push({~n[7:0], n[7:0]}, (n >= 50), 1'b0);
    push(16'h80FF, 1'b1, 1'b0);
    idle_drain();
    check("rect_count", oy_q.size(), 257);
    errs = 0;
    for (int n = 0; n < 256; n++) if (oy_q[n] !== {~n[7:0], n[7:0]}) errs++;
    check("rect_all_pass", errs, 0);
    check("rect_y_t50", oy_q[50], 16'hCD32);
    check("rect_y_t200", oy_q[200], 16'h37C8);
    check("next_win_t", ot_q[256], 0);
    check("next_win_y", oy_q[256], 16'h0101);
    clear_logs();

    // backpressure: hold i_ready low 5 cycles from the first o_valid
    restart_idle();
    fork
      begin
        for (int n = 0; n < 20; n++) push({8'h00, n[7:0]}, 1'b0, 1'b0);
        idle_drain();
      end
      begin
        g = 0;
        while (!o_valid && g < 50) begin
          @(posedge i_clk); #2;
          g++;
        end
        if (g >= 50) check("bp_ovalid_timeout", 32'd0, 32'd1);
        i_ready = 1'b0;
        lows = 0; unstable = 0;
        hold_y = o_y; hold_t = o_t;
        for (int k = 0; k < 5; k++) begin
          @(negedge i_clk); #1;
          if (k == 0) check("bp_held_when_full", acyc_q.size(), 2);
          if (!o_ready) lows++;
          if (!o_valid || o_y !== hold_y || o_t !== hold_t) unstable++;
        end
        check("bp_oready_low", lows, 5);
        check("bp_stable", unstable, 0);
        @(posedge i_clk); #1;
        i_ready = 1'b1;
      end
    join
    check("bp_count", oy_q.size(), 20);
    errs = 0;
    for (int n = 0; n < 20; n++)
      if (ot_q[n] !== n[7:0] || oy_q[n] !== {8'h00, n[7:0]}) errs++;
    check("bp_order", errs, 0);
    clear_logs();

    // wrap after 256, then restart where t would be 100
    restart_idle();
    for (int n = 0; n < 358; n++) push(16'h80FF, 1'b1, (n == 356));
    idle_drain();
    check("wr_count", oy_q.size(), 358);
    check("wr_t_255", ot_q[255], 255);
    check("wr_t_256", ot_q[256], 0);
    check("wr_t_299", ot_q[299], 43);
    check("wr_t_before_rs", ot_q[355], 99);
    check("rs_t", ot_q[356], 0);
    check("rs_y", oy_q[356], 16'h0101);
    check("rs_next_t", ot_q[357], 1);
    check("rs_next_y", oy_q[357], 16'h0203);
    clear_logs();

    // async reset mid-stream
    restart_idle();
    for (int n = 0; n < 5; n++) push(16'h1234, 1'b0, 1'b0);
    @(posedge i_clk); #3;
    check("ar_pre_valid", o_valid, 1);
    i_rst = 1'b1;
    #1;
    check("ar_valid_drop", o_valid, 0);
    check("ar_o_y", o_y, 0);
    check("ar_o_t", o_t, 0);
    check("ar_o_ready", o_ready, 1);
    i_valid = 1'b0;
    @(posedge i_clk); @(posedge i_clk); #3;
    i_rst = 1'b0;
    clear_logs();
    push(16'h80FF, 1'b1, 1'b0);
    idle_drain();
    check("ar_count", oy_q.size(), 1);
    check("ar_first_t", ot_q[0], 0);
    check("ar_first_y", oy_q[0], 16'h0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
